// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined NUM_IN:1 mux tree of registered 4:1 stages with valid/ready and auto-scan.
// Define MUX_PARITY_EN to add the registered even-parity output out_par.
module mux_tree_pipe #(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 16,
    localparam int SEL_W = $clog2(NUM_IN),
    localparam int LEVELS = SEL_W / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     scan_en,
    input  logic                     scan_clr,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic                     out_par
`endif
);
    logic             stall;
    logic             accept;
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] eff;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst_n | ~stall;
    assign accept   = in_valid & in_ready;
    assign eff      = scan_en ? scan_ptr : sel;

    always_ff @(posedge clk) begin
        if (!rst_n)
            scan_ptr <= '0;
        else
            scan_ptr <= scan_clr ? '0 : (accept & scan_en) ? scan_ptr + SEL_W'(1) : scan_ptr;
    end

    // Level g narrows NUM_IN>>(2g) channels to NUM_IN>>(2g+2), steered by select bits [2g+1:2g].
    for (genvar g = 0; g < LEVELS; g++) begin : lv
        localparam int N = NUM_IN >> (2 * g + 2);
        logic [4*N*DATA_W-1:0] src;
        logic [SEL_W-1:0]      ssrc;
        logic                  vsrc;
        logic [N*DATA_W-1:0]   nx;
        logic [N*DATA_W-1:0]   d;
        logic [SEL_W-1:0]      s;
        logic                  v;
        if (g == 0) begin : f
            assign src  = in_data;
            assign ssrc = eff;
            assign vsrc = accept;
        end else begin : f
            assign src  = lv[g-1].d;
            assign ssrc = lv[g-1].s;
            assign vsrc = lv[g-1].v;
        end
        always_comb begin
            nx = '0;
            for (int j = 0; j < N; j++)
                nx[j*DATA_W +: DATA_W] = src[(4 * j + int'(ssrc[2*g +: 2]))*DATA_W +: DATA_W];
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                d <= '0;
                s <= '0;
                v <= 1'b0;
            end else if (!stall) begin
                d <= nx;
                s <= ssrc;
                v <= vsrc;
            end
        end
    end

    assign out_data  = lv[LEVELS-1].d;
    assign out_sel   = lv[LEVELS-1].s;
    assign out_valid = lv[LEVELS-1].v;

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_par <= 1'b0;
        else if (!stall)
            out_par <= ^lv[LEVELS-1].nx;
    end
`endif
endmodule
